rd_bus_arbiter: RTL and testbench
=================================

Name: rd_bus_arbiter

Overview:
- Shares the single tiny AXI read master between the instruction-cache refill requester (IC) and the data-cache refill requester (DC).
- Latches each requester's single-cycle start pulse and address, then grants one transaction at a time using round-robin order.
- Issues the request on the shared bus and steers the returned line and the finish strobe back to the granted requester only.
- Sits between the cache refill controllers and the tiny AXI read bus interface.

Parameters:
- AWIDTH, 32, request address width.
- LWIDTH, 128, cache line data width.
- TOCYC, 1023, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dc_start_rq  in  1  DC request pulse, one cycle
- dc_rin_addr  in  AWIDTH  DC line address; valid while dc_start_rq=1
- dc_rdat_data  out  LWIDTH  returned line to DC
- dc_rdat_valid  out  1  DC data strobe
- dc_finish_mrd  out  1  DC transaction done
- ic_start_rq  in  1  IC request pulse
- ic_rin_addr  in  AWIDTH  IC line address
- ic_rdat_data  out  LWIDTH  returned line to IC
- ic_rdat_valid  out  1  IC data strobe
- ic_finish_mrd  out  1  IC transaction done
- m_start_rq  out  1  bus request, registered
- m_rin_addr  out  AWIDTH  bus address, registered
- m_rqfull  in  1  bus cannot accept a request this cycle
- m_rdat_data  in  LWIDTH  bus read data
- m_rdat_valid  in  1  bus data strobe
- m_finish_mrd  in  1  bus transaction done
- arb_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; pending bits 0; address latches 0; last_grant = IC, so DC wins the first tie.
- Per-requester pending bit and address latch:
  - A start pulse sets pending and captures the address at the clock edge.
  - A pulse arriving while that requester is already pending or outstanding is dropped, and arb_err is set.
  - Clearing pending at issue and a new pulse in the same cycle: the new pulse is accepted and pending stays 1.
- State IDLE:
  - If any pending bit is set, select the requester. With both pending, pick the one that is not last_grant.
  - Load m_rin_addr from that requester's latch, clear its pending bit, set grant, and go to ISSUE.
  - The IDLE decision uses only registered pending bits, not same-cycle pulses.
- State ISSUE:
  - m_start_rq=1 and m_rin_addr is held stable.
  - m_rqfull=1: stay in ISSUE.
  - m_rqfull=0: the request is accepted; go to WAIT next cycle, with m_start_rq=0 in that cycle.
- State WAIT:
  - m_rdat_data drives both *_rdat_data outputs.
  - m_rdat_valid and m_finish_mrd are routed combinationally to the granted requester only; the other requester sees 0.
  - On m_finish_mrd=1: update last_grant to the granted requester and go to IDLE.
- Strobes outside WAIT: m_rdat_valid or m_finish_mrd received outside WAIT is not forwarded and sets arb_err.
- Latency: pulse in cycle N -> pending in N+1 -> m_start_rq=1 in N+2 when the bus is idle and m_rqfull=0.
- Throughput: minimum one idle cycle between m_finish_mrd and the next m_start_rq.
- Multi-beat transactions: multiple m_rdat_valid pulses within one WAIT are all forwarded.
- Illegal state encodings: return to IDLE and set arb_err.
- arb_err: cleared only by reset.
- Reset mid-transaction: all state is discarded; any in-flight bus response is treated as spurious and sets arb_err.

Optional Feature:
- Macro: RD_ARB_TIMEOUT_EN.
- When defined:
  - A 10-bit counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TOCYC: arb_err=1, a one-cycle *_finish_mrd is pulsed to the granted requester so it unstalls, last_grant is updated, and the state goes to IDLE.
  - A late m_finish_mrd for the abandoned transaction sets arb_err and is not forwarded.
- When not defined: no counter; WAIT lasts until m_finish_mrd.

Test Plan:
- DC-only read:
  - Stimulus: dc_start_rq pulse with addr 0x0000_1230.
  - Required: m_start_rq=1 two cycles later with m_rin_addr=0x0000_1230.
  - Then m_rdat_valid with data 0xA5..A5 -> dc_rdat_valid=1, dc_rdat_data=0xA5..A5, ic_rdat_valid=0; m_finish_mrd -> dc_finish_mrd=1.
- Simultaneous requests:
  - Stimulus: dc and ic pulse in the same cycle, addrs 0x100 and 0x200.
  - Required: first issue is 0x100 (DC); second issue is 0x200 one cycle after IDLE is re-entered.
  - Repeating the pair gives DC first again, because last_grant is then IC.
- Backpressure:
  - Stimulus: m_rqfull=1 for 5 cycles while in ISSUE.
  - Required: m_start_rq held at 1 for 6 cycles with the address stable; WAIT is entered after the cycle with m_rqfull=0.
- Pulse during outstanding transaction:
  - Stimulus: ic pulse at addr 0x300 while the IC transaction is in WAIT.
  - Required: arb_err=1, and no second IC issue follows.
  - Separately: an IC pulse at addr 0x300 in the same cycle its pending bit is cleared at issue -> accepted, and 0x300 is issued after finish.
- Spurious strobe and reset:
  - Stimulus: m_rdat_valid=1 in IDLE.
  - Required: no *_rdat_valid output, arb_err=1.
  - Stimulus: assert rst_n=0 while in WAIT.
  - Required: all outputs 0 and state IDLE immediately.
- RD_ARB_TIMEOUT_EN with TOCYC=20:
  - Stimulus: never return m_finish_mrd.
  - Required: 20 cycles after entering ISSUE, dc_finish_mrd pulses and arb_err=1; a pending IC request issues next.

Source files
------------

// File: rtl/rd_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// rd_bus_arbiter_if: shared tiny AXI read-master bus between arbiter and bus IF
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rd_bus_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 128
);
  logic              m_start_rq;
  logic [AWIDTH-1:0] m_rin_addr;
  logic              m_rqfull;
  logic [LWIDTH-1:0] m_rdat_data;
  logic              m_rdat_valid;
  logic              m_finish_mrd;

  modport master (
    output m_start_rq, m_rin_addr,
    input  m_rqfull, m_rdat_data, m_rdat_valid, m_finish_mrd
  );

  modport slave (
    input  m_start_rq, m_rin_addr,
    output m_rqfull, m_rdat_data, m_rdat_valid, m_finish_mrd
  );
endinterface

`default_nettype wire

// File: rtl/rd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rd_bus_arbiter: round-robin IC/DC refill arbiter onto one read bus master.
// Optional watchdog enabled by defining RD_ARB_TIMEOUT_EN. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_bus_arbiter #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 128,
  parameter int TOCYC  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dc_start_rq,
  input  logic [AWIDTH-1:0] dc_rin_addr,
  output logic [LWIDTH-1:0] dc_rdat_data,
  output logic              dc_rdat_valid,
  output logic              dc_finish_mrd,
  input  logic              ic_start_rq,
  input  logic [AWIDTH-1:0] ic_rin_addr,
  output logic [LWIDTH-1:0] ic_rdat_data,
  output logic              ic_rdat_valid,
  output logic              ic_finish_mrd,
  rd_bus_arbiter_if.master  bus,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              grant_dc_q, grant_dc_d;   // 1: DC owns the bus, 0: IC
  logic              last_dc_q, last_dc_d;     // 1: last completed grant was DC
  logic              start_q, start_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              dc_pend_q, dc_pend_d;
  logic              ic_pend_q, ic_pend_d;
  logic [AWIDTH-1:0] dc_addr_q, dc_addr_d;
  logic [AWIDTH-1:0] ic_addr_q, ic_addr_d;

  logic              sel_dc;
  logic              dc_clr, ic_clr;
  logic              dc_acc, ic_acc;
  logic              fwd;
  logic              to_fire;
  logic              err_set;

`ifdef RD_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LIM = TOCYC[9:0];
  logic [9:0] cnt_q, cnt_d;
`else
  logic tocyc_unused;
  assign tocyc_unused = (TOCYC != 0);
`endif

  always_comb begin
    state_d    = state_q;
    grant_dc_d = grant_dc_q;
    last_dc_d  = last_dc_q;
    start_d    = start_q;
    addr_d     = addr_q;
    sel_dc     = 1'b0;
    dc_clr     = 1'b0;
    ic_clr     = 1'b0;
    fwd        = 1'b0;
    to_fire    = 1'b0;
    err_set    = 1'b0;
`ifdef RD_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (dc_pend_q || ic_pend_q) begin
          sel_dc     = dc_pend_q && (!ic_pend_q || !last_dc_q);
          addr_d     = sel_dc ? dc_addr_q : ic_addr_q;
          dc_clr     = sel_dc;
          ic_clr     = !sel_dc;
          grant_dc_d = sel_dc;
          start_d    = 1'b1;
          state_d    = ST_ISSUE;
`ifdef RD_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (!bus.m_rqfull) begin
          start_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        fwd = 1'b1;
        if (bus.m_finish_mrd) begin
          last_dc_d = grant_dc_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
        err_set = 1'b1;
      end
    endcase

`ifdef RD_ARB_TIMEOUT_EN
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      cnt_d = cnt_q + 10'd1;
      // A genuine finish in the same cycle wins over the watchdog.
      if (cnt_q == TO_LIM && !(fwd && bus.m_finish_mrd)) begin
        to_fire   = 1'b1;
        err_set   = 1'b1;
        last_dc_d = grant_dc_q;
        start_d   = 1'b0;
        state_d   = ST_IDLE;
      end
    end
`endif

    if (!fwd && (bus.m_rdat_valid || bus.m_finish_mrd))
      err_set = 1'b1;

    // A pulse is only refused if it would overwrite a live request.
    dc_acc    = dc_start_rq && !((dc_pend_q && !dc_clr) ||
                                 (state_q != ST_IDLE && grant_dc_q));
    ic_acc    = ic_start_rq && !((ic_pend_q && !ic_clr) ||
                                 (state_q != ST_IDLE && !grant_dc_q));
    dc_pend_d = dc_acc || (dc_pend_q && !dc_clr);
    ic_pend_d = ic_acc || (ic_pend_q && !ic_clr);
    dc_addr_d = dc_acc ? dc_rin_addr : dc_addr_q;
    ic_addr_d = ic_acc ? ic_rin_addr : ic_addr_q;
    if ((dc_start_rq && !dc_acc) || (ic_start_rq && !ic_acc))
      err_set = 1'b1;

    err_d = err_q || err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_dc_q <= 1'b0;
      last_dc_q  <= 1'b0;
      start_q    <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      dc_pend_q  <= 1'b0;
      ic_pend_q  <= 1'b0;
      dc_addr_q  <= '0;
      ic_addr_q  <= '0;
`ifdef RD_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_dc_q <= grant_dc_d;
      last_dc_q  <= last_dc_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      dc_pend_q  <= dc_pend_d;
      ic_pend_q  <= ic_pend_d;
      dc_addr_q  <= dc_addr_d;
      ic_addr_q  <= ic_addr_d;
`ifdef RD_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.m_start_rq = start_q;
  assign bus.m_rin_addr = addr_q;
  assign arb_err        = err_q;

  assign dc_rdat_data  = fwd ? bus.m_rdat_data : '0;
  assign ic_rdat_data  = fwd ? bus.m_rdat_data : '0;
  assign dc_rdat_valid = fwd && grant_dc_q && bus.m_rdat_valid;
  assign ic_rdat_valid = fwd && !grant_dc_q && bus.m_rdat_valid;
  assign dc_finish_mrd = grant_dc_q && ((fwd && bus.m_finish_mrd) || to_fire);
  assign ic_finish_mrd = !grant_dc_q && ((fwd && bus.m_finish_mrd) || to_fire);

endmodule

`default_nettype wire

// File: tb/tb_rd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rd_bus_arbiter: directed self-checking bench for rd_bus_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rd_bus_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dc_start_rq = 1'b0;
  logic [AW-1:0] dc_rin_addr = '0;
  logic [LW-1:0] dc_rdat_data;
  logic          dc_rdat_valid;
  logic          dc_finish_mrd;
  logic          ic_start_rq = 1'b0;
  logic [AW-1:0] ic_rin_addr = '0;
  logic [LW-1:0] ic_rdat_data;
  logic          ic_rdat_valid;
  logic          ic_finish_mrd;
  logic          arb_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [LW-1:0] pat_a5;

  rd_bus_arbiter_if #(.AWIDTH(AW), .LWIDTH(LW)) bus_if ();

  rd_bus_arbiter #(.AWIDTH(AW), .LWIDTH(LW), .TOCYC(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dc_start_rq   (dc_start_rq),
    .dc_rin_addr   (dc_rin_addr),
    .dc_rdat_data  (dc_rdat_data),
    .dc_rdat_valid (dc_rdat_valid),
    .dc_finish_mrd (dc_finish_mrd),
    .ic_start_rq   (ic_start_rq),
    .ic_rin_addr   (ic_rin_addr),
    .ic_rdat_data  (ic_rdat_data),
    .ic_rdat_valid (ic_rdat_valid),
    .ic_finish_mrd (ic_finish_mrd),
    .bus           (bus_if),
    .arb_err       (arb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Simultaneous DC/IC pulses: DC must issue first, IC one cycle after IDLE.
  task automatic run_pair(input string tag);
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h100;
    ic_start_rq = 1'b1; ic_rin_addr = 32'h200;
    tick();
    dc_start_rq = 1'b0; ic_start_rq = 1'b0;
    tick();
    chk({tag, "_first_rq"}, LW'(bus_if.m_start_rq), 1);
    chk({tag, "_first_addr"}, LW'(bus_if.m_rin_addr), 32'h100);
    tick();
    bus_if.m_finish_mrd = 1'b1;
    #1;
    chk({tag, "_dc_fin"}, LW'(dc_finish_mrd), 1);
    chk({tag, "_ic_nofin"}, LW'(ic_finish_mrd), 0);
    tick();
    bus_if.m_finish_mrd = 1'b0;
    chk({tag, "_idle_gap"}, LW'(bus_if.m_start_rq), 0);
    tick();
    chk({tag, "_second_rq"}, LW'(bus_if.m_start_rq), 1);
    chk({tag, "_second_addr"}, LW'(bus_if.m_rin_addr), 32'h200);
    tick();
    bus_if.m_finish_mrd = 1'b1;
    #1;
    chk({tag, "_ic_fin"}, LW'(ic_finish_mrd), 1);
    chk({tag, "_dc_nofin"}, LW'(dc_finish_mrd), 0);
    tick();
    bus_if.m_finish_mrd = 1'b0;
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    bus_if.m_rqfull     = 1'b0;
    bus_if.m_rdat_data  = '0;
    bus_if.m_rdat_valid = 1'b0;
    bus_if.m_finish_mrd = 1'b0;

    #1;
    chk("rst_start_rq", LW'(bus_if.m_start_rq), 0);
    chk("rst_addr", LW'(bus_if.m_rin_addr), 0);
    chk("rst_err", LW'(arb_err), 0);
    chk("rst_dc_fin", LW'(dc_finish_mrd), 0);
    chk("rst_ic_valid", LW'(ic_rdat_valid), 0);
    tick();
    rst_n = 1'b1;

    run_pair("pair1");
    run_pair("pair2");
    chk("pair_err", LW'(arb_err), 0);

    // DC-only read with one data beat
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h0000_1230;
    tick();
    dc_start_rq = 1'b0;
    chk("dc_lat_n1", LW'(bus_if.m_start_rq), 0);
    tick();
    chk("dc_lat_n2", LW'(bus_if.m_start_rq), 1);
    chk("dc_addr", LW'(bus_if.m_rin_addr), 32'h0000_1230);
    tick();
    chk("dc_wait_rq", LW'(bus_if.m_start_rq), 0);
    bus_if.m_rdat_valid = 1'b1; bus_if.m_rdat_data = pat_a5;
    #1;
    chk("dc_rvalid", LW'(dc_rdat_valid), 1);
    chk("dc_rdata", dc_rdat_data, pat_a5);
    chk("ic_rvalid_off", LW'(ic_rdat_valid), 0);
    tick();
    bus_if.m_rdat_valid = 1'b1; bus_if.m_rdat_data = ~pat_a5;
    #1;
    chk("dc_beat2", dc_rdat_data, ~pat_a5);
    tick();
    bus_if.m_rdat_valid = 1'b0; bus_if.m_finish_mrd = 1'b1;
    #1;
    chk("dc_fin", LW'(dc_finish_mrd), 1);
    tick();
    bus_if.m_finish_mrd = 1'b0;
    chk("dc_err", LW'(arb_err), 0);

    // Backpressure: rqfull for 5 ISSUE cycles
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h400;
    tick();
    dc_start_rq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus_if.m_rqfull = (i < 5);
      chk($sformatf("bp_rq_%0d", i), LW'(bus_if.m_start_rq), 1);
      chk($sformatf("bp_addr_%0d", i), LW'(bus_if.m_rin_addr), 32'h400);
    end
    tick();
    chk("bp_wait_rq", LW'(bus_if.m_start_rq), 0);
    bus_if.m_rdat_valid = 1'b1;
    #1;
    chk("bp_wait_valid", LW'(dc_rdat_valid), 1);
    tick();
    bus_if.m_rdat_valid = 1'b0; bus_if.m_finish_mrd = 1'b1;
    tick();
    bus_if.m_finish_mrd = 1'b0;

    // IC pulse while its own transaction is outstanding
    tick();
    ic_start_rq = 1'b1; ic_rin_addr = 32'h280;
    tick();
    ic_start_rq = 1'b0;
    tick();
    chk("out_issue_addr", LW'(bus_if.m_rin_addr), 32'h280);
    tick();
    ic_start_rq = 1'b1; ic_rin_addr = 32'h300;
    tick();
    ic_start_rq = 1'b0;
    chk("out_err", LW'(arb_err), 1);
    bus_if.m_finish_mrd = 1'b1;
    #1;
    chk("out_ic_fin", LW'(ic_finish_mrd), 1);
    tick();
    bus_if.m_finish_mrd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("out_no_reissue_%0d", i), LW'(bus_if.m_start_rq), 0);
    end

    // IC pulse in the cycle its pending bit clears at issue
    do_reset();
    chk("clr_err_reset", LW'(arb_err), 0);
    tick();
    ic_start_rq = 1'b1; ic_rin_addr = 32'h280;
    tick();
    ic_rin_addr = 32'h300;
    tick();
    ic_start_rq = 1'b0;
    chk("clr_first_addr", LW'(bus_if.m_rin_addr), 32'h280);
    tick();
    bus_if.m_finish_mrd = 1'b1;
    tick();
    bus_if.m_finish_mrd = 1'b0;
    tick();
    chk("clr_second_rq", LW'(bus_if.m_start_rq), 1);
    chk("clr_second_addr", LW'(bus_if.m_rin_addr), 32'h300);
    tick();
    bus_if.m_finish_mrd = 1'b1;
    #1;
    chk("clr_second_fin", LW'(ic_finish_mrd), 1);
    tick();
    bus_if.m_finish_mrd = 1'b0;
    chk("clr_no_err", LW'(arb_err), 0);

    // Spurious strobe in IDLE
    tick();
    bus_if.m_rdat_valid = 1'b1;
    #1;
    chk("spur_dc_valid", LW'(dc_rdat_valid), 0);
    chk("spur_ic_valid", LW'(ic_rdat_valid), 0);
    tick();
    bus_if.m_rdat_valid = 1'b0;
    chk("spur_err", LW'(arb_err), 1);

    // Reset asserted while in WAIT, response still in flight
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h600;
    tick();
    dc_start_rq = 1'b0;
    tick();
    tick();
    bus_if.m_rdat_valid = 1'b1;
    #1;
    chk("rstw_valid_pre", LW'(dc_rdat_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_valid", LW'(dc_rdat_valid), 0);
    chk("rstw_data", dc_rdat_data, 0);
    chk("rstw_rq", LW'(bus_if.m_start_rq), 0);
    chk("rstw_err", LW'(arb_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_if.m_rdat_valid = 1'b0;
    chk("rstw_spur_err", LW'(arb_err), 1);
    chk("rstw_idle_rq", LW'(bus_if.m_start_rq), 0);

`ifdef RD_ARB_TIMEOUT_EN
    // Watchdog: DC never finishes, pending IC issues afterwards
    do_reset();
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h700;
    tick();
    dc_start_rq = 1'b0;
    tick();
    chk("to_issue", LW'(bus_if.m_start_rq), 1);
    ic_start_rq = 1'b1; ic_rin_addr = 32'h800;
    for (int i = 1; i < 20; i++) begin
      tick();
      ic_start_rq = 1'b0;
      chk($sformatf("to_nofin_%0d", i), LW'(dc_finish_mrd), 0);
    end
    tick();
    chk("to_fin", LW'(dc_finish_mrd), 1);
    chk("to_ic_nofin", LW'(ic_finish_mrd), 0);
    tick();
    chk("to_err", LW'(arb_err), 1);
    chk("to_fin_once", LW'(dc_finish_mrd), 0);
    tick();
    chk("to_ic_rq", LW'(bus_if.m_start_rq), 1);
    chk("to_ic_addr", LW'(bus_if.m_rin_addr), 32'h800);
`else
    // Without the watchdog WAIT lasts until the bus finishes
    do_reset();
    tick();
    dc_start_rq = 1'b1; dc_rin_addr = 32'h700;
    tick();
    dc_start_rq = 1'b0;
    tick();
    chk("nto_issue", LW'(bus_if.m_start_rq), 1);
    for (int i = 0; i < 30; i++) tick();
    chk("nto_nofin", LW'(dc_finish_mrd), 0);
    chk("nto_err", LW'(arb_err), 0);
    bus_if.m_finish_mrd = 1'b1;
    #1;
    chk("nto_fin", LW'(dc_finish_mrd), 1);
    tick();
    bus_if.m_finish_mrd = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
